sram_controller: RTL and testbench

Bridges the memory stage and cache to the off-chip-style 32-bit SRAM model, which has a 16-bit word address, an active-low write enable, a bidirectional data bus and a 30 ns read access time. It turns single-cycle read/write requests into multi-cycle SRAM bus sequences and deasserts `ready` to freeze the pipeline while an access is in flight. Reads return a full 64-bit cache line (two consecutive words). Writes store one 32-bit word.

---
 rtl/sram_ctrl_pkg.sv | 30 +++
 rtl/sram_controller_if.sv | 28 ++
 rtl/sram_controller_access_timer.sv | 33 +++
 rtl/sram_controller.sv | 103 ++++++++++
 tb/tb_sram_controller.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_pkg
// Purpose  : Shared types and constants for the SRAM controller slice.
// Revision : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

    localparam int SRAM_BASE_ADDR = 1024;
    localparam int SRAM_AW        = 16;
    localparam int SRAM_DW        = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ_LO = 3'd2,
        READ_HI = 3'd3,
        DONE    = 3'd4
    } sram_state_t;

    // Byte address to SRAM word index; out-of-range offsets simply wrap.
    function automatic logic [SRAM_AW-1:0] sram_word_idx(
        input logic [31:0] byte_addr,
        input logic [31:0] base
    );
        return SRAM_AW'((byte_addr - base) >> 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller_if
// Purpose  : Request/response bus between the memory stage and the
//            SRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_controller_if;

    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [63:0] rdata;
    logic        ready;

    modport master (
        output mem_r_en, mem_w_en, address, wdata,
        input  rdata, ready
    );

    modport slave (
        input  mem_r_en, mem_w_en, address, wdata,
        output rdata, ready
    );

endinterface
`default_nettype wire

// File: rtl/sram_controller_access_timer.sv
`default_nettype none
// ============================================================================
// Module   : access_timer
// Purpose  : Counts the cycles of one SRAM access phase and flags the last.
// Revision : 1.0 - initial release
// ============================================================================
module access_timer #(
    parameter int ACCESS_CYCLES = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    output logic      last
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(ACCESS_CYCLES - 1);

    logic [CW-1:0] count;

    // Count up from zero; clear is pulsed by the FSM ahead of every state entry.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Purpose  : Turns single-cycle read/write requests into timed SRAM bus
//            sequences; reads fetch a 64-bit line, writes store one word.
// Revision : 1.0 - initial release
// ============================================================================
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int ACCESS_CYCLES = 4,
    parameter int BASE_ADDR     = SRAM_BASE_ADDR
) (
    input  wire logic                clk,
    input  wire logic                rst,
    sram_controller_if.slave         bus,
    output logic                     WE_N_SRAM,
    output logic [SRAM_AW-1:0]       address_SRAM,
    inout  wire  [SRAM_DW-1:0]       data_SRAM
);

    sram_state_t        state;
    logic               timer_last;
    logic               timer_clear;
    logic [SRAM_AW-1:0] word_idx;
    logic [SRAM_AW-1:0] line_lo;
    logic [SRAM_AW-1:0] line_hi;

    assign word_idx = sram_word_idx(bus.address, 32'(BASE_ADDR));
    assign line_lo  = {word_idx[SRAM_AW-1:1], 1'b0};
    assign line_hi  = {word_idx[SRAM_AW-1:1], 1'b1};

    // Hold the counter at zero outside timed phases and restart it whenever a
    // phase ends, so each new state starts counting from zero.
    assign timer_clear = (state == IDLE) || (state == DONE) || timer_last;

    access_timer #(
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .last  (timer_last)
    );

    // Freeze the pipeline from the request cycle until the DONE cycle.
    assign bus.ready = ((state == IDLE) && !(bus.mem_r_en || bus.mem_w_en)) ||
                       (state == DONE);

    // Drive the shared data bus only while a write is in flight.
    assign data_SRAM = WE_N_SRAM ? {SRAM_DW{1'bz}} : bus.wdata;

    // Access sequencer with registered SRAM controls and read-line capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            WE_N_SRAM    <= 1'b1;
            address_SRAM <= '0;
            bus.rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_w_en) begin
                        state        <= WRITE;
                        address_SRAM <= word_idx;
                        WE_N_SRAM    <= 1'b0;
                    end else if (bus.mem_r_en) begin
                        state        <= READ_LO;
                        address_SRAM <= line_lo;
                    end
                end
                WRITE: begin
                    if (timer_last) begin
                        state     <= DONE;
                        WE_N_SRAM <= 1'b1;
                    end
                end
                READ_LO: begin
                    if (timer_last) begin
                        bus.rdata[31:0] <= data_SRAM;
                        address_SRAM    <= line_hi;
                        state           <= READ_HI;
                    end
                end
                READ_HI: begin
                    if (timer_last) begin
                        bus.rdata[63:32] <= data_SRAM;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    WE_N_SRAM <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_controller
// Purpose  : Scoreboard bench for sram_controller with an attached SRAM
//            model and a word-level reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_controller;
    import sram_ctrl_pkg::*;

    localparam int AC   = 4;
    localparam int BASE = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_controller_if bus();
    logic        WE_N_SRAM;
    logic [15:0] address_SRAM;
    wire  [31:0] data_SRAM;

    sram_controller #(
        .ACCESS_CYCLES (AC),
        .BASE_ADDR     (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .WE_N_SRAM    (WE_N_SRAM),
        .address_SRAM (address_SRAM),
        .data_SRAM    (data_SRAM)
    );

    // ---------------- SRAM model: 30 ns read access, write on clock edge ----
    logic [31:0] sram_mem [0:65535] = '{default: 32'h0};
    logic [31:0] sram_drive;

    assign data_SRAM = WE_N_SRAM ? sram_drive : 32'bz;

    always @(posedge clk) begin
        if (!WE_N_SRAM) sram_mem[address_SRAM] <= data_SRAM;
    end

    always @(address_SRAM or WE_N_SRAM) begin
        sram_drive = 32'hA5A5_A5A5;
        #30;
        sram_drive = sram_mem[address_SRAM];
    end

    // ---------------- Reference model -------------------------------------
    logic [31:0] ref_mem [int];
    logic [63:0] ref_rdata = 64'h0;

    function automatic logic [31:0] ref_rd(int i);
        return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
    endfunction

    function automatic int word_of(logic [31:0] a);
        longint d;
        d = longint'(a) - BASE;
        return int'(((d / 4) % 65536 + 65536) % 65536);
    endfunction

    // ---------------- Scoreboard ------------------------------------------
    typedef struct {
        bit          is_write;
        int          idx;
        logic [31:0] wdata;
        logic [63:0] rdata;
        logic [15:0] a1;
        logic [15:0] a2;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Monitor ---------------------------------------------
    bit          mon_en     = 1'b0;
    bit          prev_ready = 1'b1;
    int          low_cnt    = 0;
    int          wel_cnt    = 0;
    logic [15:0] a1_seen    = 16'h0;
    logic [15:0] a2_seen    = 16'h0;
    exp_t        m_e;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ready && !prev_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'(bus.ready), 64'h0);
                end else begin
                    m_e = sb_q.pop_front();
                    check("rdata", bus.rdata, m_e.rdata);
                    check("we_n_in_done", 64'(WE_N_SRAM), 64'h1);
                    check("ready_low_cycles", 64'(low_cnt),
                          m_e.is_write ? 64'(AC + 1) : 64'(2 * AC + 1));
                    check("we_low_cycles", 64'(wel_cnt),
                          m_e.is_write ? 64'(AC) : 64'h0);
                    check("addr_first_phase", 64'(a1_seen), 64'(m_e.a1));
                    if (m_e.is_write)
                        check("sram_word", 64'(sram_mem[m_e.idx]), 64'(m_e.wdata));
                    else
                        check("addr_second_phase", 64'(a2_seen), 64'(m_e.a2));
                end
                low_cnt = 0;
                wel_cnt = 0;
            end
            if (!bus.ready) begin
                if (low_cnt == 1)      a1_seen = address_SRAM;
                if (low_cnt == AC + 1) a2_seen = address_SRAM;
                low_cnt++;
            end
            if (!WE_N_SRAM) wel_cnt++;
            prev_ready = bus.ready;
        end else begin
            low_cnt    = 0;
            wel_cnt    = 0;
            prev_ready = 1'b1;
        end
    end

    // ---------------- Stimulus --------------------------------------------
    task automatic issue(bit r, bit w, logic [31:0] a, logic [31:0] d);
        exp_t e;
        int   i;
        int   lo;
        bit   got;
        i  = word_of(a);
        lo = i - (i % 2);
        if (w)      ref_mem[i] = d;
        else if (r) ref_rdata = {ref_rd(lo + 1), ref_rd(lo)};
        e.is_write = w;
        e.idx      = i;
        e.wdata    = d;
        e.rdata    = ref_rdata;
        e.a1       = w ? 16'(i) : 16'(lo);
        e.a2       = 16'(lo + 1);
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.mem_r_en = r;
        bus.mem_w_en = w;
        bus.address  = a;
        bus.wdata    = d;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("timeout_waiting_ready", 64'h0, 64'h1);
        @(posedge clk); #1;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
    endtask

    initial begin
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        bus.address  = 32'(BASE);
        bus.wdata    = 32'h0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_we_n",  64'(WE_N_SRAM),    64'h1);
        check("reset_rdata", bus.rdata,         64'h0);
        check("reset_ready", 64'(bus.ready),    64'h1);
        check("reset_addr",  64'(address_SRAM), 64'h0);
        mon_en = 1'b1;

        issue(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
        issue(1'b0, 1'b1, 32'd1028, 32'h1234_5678);
        issue(1'b1, 1'b0, 32'd1024, 32'h0);
        check("line_1024", bus.rdata, 64'h12345678_DEADBEEF);
        issue(1'b1, 1'b0, 32'd1028, 32'h0);
        check("line_1028", bus.rdata, 64'h12345678_DEADBEEF);
        issue(1'b1, 1'b1, 32'd1032, 32'h7);
        check("both_en_rdata_kept", bus.rdata, 64'h12345678_DEADBEEF);
        check("both_en_word2", 64'(sram_mem[2]), 64'h7);

        for (int n = 0; n < 60; n++) begin
            int          sel;
            logic [31:0] a;
            sel = int'($urandom_range(0, 9));
            a   = 32'(BASE + 4 * (int'($urandom_range(0, 17)) - 2));
            if (sel < 5)      issue(1'b0, 1'b1, a, $urandom);
            else if (sel < 9) issue(1'b1, 1'b0, a, $urandom);
            else              issue(1'b1, 1'b1, a, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Reset in the third READ_HI cycle of a read from 1024.
        mon_en = 1'b0;
        @(posedge clk); #1;
        bus.mem_r_en = 1'b1;
        bus.address  = 32'd1024;
        repeat (7) @(posedge clk);
        check("busy_before_reset", 64'(bus.ready), 64'h0);
        #1;
        rst          = 1'b1;
        bus.mem_r_en = 1'b0;
        @(posedge clk); #1;
        check("midreset_rdata", bus.rdata,         64'h0);
        check("midreset_we_n",  64'(WE_N_SRAM),    64'h1);
        check("midreset_ready", 64'(bus.ready),    64'h1);
        check("midreset_addr",  64'(address_SRAM), 64'h0);
        rst       = 1'b0;
        ref_rdata = 64'h0;
        @(negedge clk);
        mon_en = 1'b1;
        issue(1'b1, 1'b0, 32'd1024, 32'h0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
